imm_gen_pipe: RTL and testbench

//   Registered, flow-controlled immediate generator for the decode stage.
//   - Decodes all five RV32 immediate formats (I/S/B/U/J) from the full instruction word.
//   - Sign-extends each immediate to WORD_LEN.
//   - Optionally produces the PC-relative target (pc + imm).
//   - A valid/ready 2-entry skid buffer decouples decode from the execute/branch unit.

---
 rtl/imm_gen_pipe_if.sv | 27 ++
 rtl/imm_gen_pipe.sv | 156 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Bundle of the upstream (decode) and downstream (execute) handshake signals
// of imm_gen_pipe. The block uses the slave view; the driver/monitor uses master.
interface imm_gen_pipe_if #(
    parameter int WORD_LEN  = 32,
    parameter int ADDR_SIZE = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic [4:0]           immctrl;
    logic [ADDR_SIZE-1:0] pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_LEN-1:0]  immout;
    logic [ADDR_SIZE-1:0] target;
    logic                 err;

    modport master (
        output in_valid, instr, immctrl, pc, out_ready,
        input  in_ready, out_valid, immout, target, err
    );

    modport slave (
        input  in_valid, instr, immctrl, pc, out_ready,
        output in_ready, out_valid, immout, target, err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32 immediate generator behind a 2-entry valid/ready skid buffer.
// Define IMM_TARGET_EN to build the pc + imm target adder and its storage.
module imm_gen_pipe #(
    parameter int WORD_LEN  = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [WORD_LEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic                main_err_q, main_err_d, skid_err_q, skid_err_d;
    logic [WORD_LEN-1:0] new_imm;
    logic                new_err;
    logic                out_valid, accept, pop;
    logic                load_main_new, load_main_skid, load_skid;
    logic                unused_opcode;

    assign out_valid     = (state_q != EMPTY);
    assign accept        = bus.in_valid & in_ready_q;
    assign pop           = out_valid & bus.out_ready;
    assign unused_opcode = ^bus.instr[6:0];

    // Decode ahead of the registers so both entries hold finished results.
    always_comb begin
        new_imm = '0;
        new_err = 1'b0;
        case (bus.immctrl)
            5'b00001: new_imm = WORD_LEN'($signed(bus.instr[31:20]));
            5'b00010: new_imm = WORD_LEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            5'b00100: new_imm = WORD_LEN'($signed({bus.instr[31], bus.instr[7],
                                                   bus.instr[30:25], bus.instr[11:8], 1'b0}));
            5'b01000: new_imm = WORD_LEN'($signed({bus.instr[31:12], 12'b0}));
            5'b10000: new_imm = WORD_LEN'($signed({bus.instr[31], bus.instr[19:12],
                                                   bus.instr[20], bus.instr[30:21], 1'b0}));
            default:  new_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main_new = 1'b1;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (pop && accept) begin
                    load_main_new = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Ready is registered from the next state so it never sees out_ready combinationally.
        in_ready_d = (state_d != FULL);
    end

    always_comb begin
        main_imm_d = main_imm_q;
        main_err_d = main_err_q;
        skid_imm_d = skid_imm_q;
        skid_err_d = skid_err_q;
        if (load_main_new) begin
            main_imm_d = new_imm;
            main_err_d = new_err;
        end else if (load_main_skid) begin
            main_imm_d = skid_imm_q;
            main_err_d = skid_err_q;
        end
        if (load_skid) begin
            skid_imm_d = new_imm;
            skid_err_d = new_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_imm_q <= '0;
            main_err_q <= 1'b0;
            skid_imm_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_imm_q <= main_imm_d;
            main_err_q <= main_err_d;
            skid_imm_q <= skid_imm_d;
            skid_err_q <= skid_err_d;
        end
    end

`ifdef IMM_TARGET_EN
    logic [ADDR_SIZE-1:0] new_tgt;
    logic [ADDR_SIZE-1:0] main_tgt_q, main_tgt_d, skid_tgt_q, skid_tgt_d;

    // An illegal format decodes to zero, so the target falls back to pc.
    assign new_tgt = bus.pc + new_imm[ADDR_SIZE-1:0];

    always_comb begin
        main_tgt_d = main_tgt_q;
        skid_tgt_d = skid_tgt_q;
        if (load_main_new) begin
            main_tgt_d = new_tgt;
        end else if (load_main_skid) begin
            main_tgt_d = skid_tgt_q;
        end
        if (load_skid) begin
            skid_tgt_d = new_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_tgt_q <= '0;
            skid_tgt_q <= '0;
        end else begin
            main_tgt_q <= main_tgt_d;
            skid_tgt_q <= skid_tgt_d;
        end
    end

    assign bus.target = main_tgt_q;
`else
    logic unused_pc;

    assign unused_pc  = ^bus.pc;
    assign bus.target = '0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.immout    = main_imm_q;
    assign bus.err       = main_err_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and randomized checks of imm_gen_pipe against a queue-based reference model.
module tb_imm_gen_pipe;
    localparam logic [4:0] C_I = 5'b00001;
    localparam logic [4:0] C_S = 5'b00010;
    localparam logic [4:0] C_B = 5'b00100;
    localparam logic [4:0] C_U = 5'b01000;
    localparam logic [4:0] C_J = 5'b10000;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    exp_t q[$];

    imm_gen_pipe_if #(.WORD_LEN(32), .ADDR_SIZE(32)) bus ();

    imm_gen_pipe #(.WORD_LEN(32), .ADDR_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Immediate assembled from field positions using signed integer arithmetic.
    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [4:0] c,
                                       input logic [31:0] p);
        exp_t e;
        int   s;
        int   imm;
        s     = $signed(ins);
        imm   = 0;
        e.err = 1'b0;
        if ($countones(c) != 1) e.err = 1'b1;
        else if (c[0]) imm = s >>> 20;
        else if (c[1]) imm = ((s >>> 25) << 5) | int'(ins[11:7]);
        else if (c[2]) imm = ((s >>> 31) << 12) | (int'(ins[7]) << 11)
                           | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
        else if (c[3]) imm = int'(ins & 32'hFFFFF000);
        else           imm = ((s >>> 31) << 20) | (int'(ins[19:12]) << 12)
                           | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
        e.imm = 32'(imm);
`ifdef IMM_TARGET_EN
        e.tgt = p + e.imm;
`else
        e.tgt = 32'(p & 32'h0);
`endif
        return e;
    endfunction

    // One clock cycle: drive, check the current outputs, then advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [4:0] c,
                        input logic [31:0] p, input logic ordy);
        exp_t e;
        logic acc;
        logic pp;
        @(negedge clk);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.immctrl   = c;
        bus.pc        = p;
        bus.out_ready = ordy;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("immout", bus.immout, q[0].imm);
            check("target", bus.target, q[0].tgt);
            check("err", 32'(bus.err), 32'(q[0].err));
        end
        acc = v && (q.size() < 2);
        pp  = (q.size() > 0) && ordy;
        e   = ref_entry(ins, c, p);
        @(posedge clk);
        if (pp) begin
            $display("pop  immout=%h target=%h err=%b", q[0].imm, q[0].tgt, q[0].err);
            void'(q.pop_front());
        end
        if (acc) q.push_back(e);
    endtask

    initial begin
        logic [4:0] c;
        checks        = 0;
        passed        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.immctrl   = '0;
        bus.pc        = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_immout", bus.immout, 32'd0);
        check("rst_target", bus.target, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        step(1'b1, 32'hFFF00093, C_I, 32'h0, 1'b1);
        step(1'b1, 32'hFE000EE3, C_B, 32'h100, 1'b1);
        step(1'b1, 32'h0080006F, C_J, 32'hFFFFFFFC, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);

        step(1'b1, 32'h12345037, C_U, 32'h200, 1'b0);
        step(1'b1, 32'hFE112E23, C_S, 32'h204, 1'b0);
        step(1'b1, 32'hDEADBEEF, C_I, 32'h208, 1'b0);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b0);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);

        step(1'b1, 32'hFFF00093, 5'b00011, 32'h300, 1'b1);
        step(1'b1, 32'h80000000, 5'b00000, 32'h304, 1'b1);
        step(1'b1, 32'h80000000, 5'b11111, 32'h308, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);

        step(1'b1, 32'h0000A037, C_U, 32'h400, 1'b0);
        step(1'b1, 32'h00100093, C_I, 32'h404, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_immout", bus.immout, 32'd0);
        check("midrst_target", bus.target, 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);
        step(1'b1, 32'h7FFFF0EF, C_J, 32'h500, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);
        step(1'b0, 32'h0, C_I, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) c = 5'($urandom_range(31));
            else c = 5'(5'b00001 << $urandom_range(4));
            step($urandom_range(3) != 0, $urandom, c, $urandom, $urandom_range(2) != 0);
        end
        repeat (4) step(1'b0, 32'h0, C_I, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
